// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers: field layout,
// NOP encoding and the stage occupancy encoding.
package pipe_pkg;

   localparam int FIELD_W_DEF = 32;

   typedef logic [31:0] word_t;

   localparam word_t NOP_INSTR = 32'h0000_0000;

   localparam int F_IR  = 0;
   localparam int F_PC  = 1;
   localparam int F_RD1 = 2;
   localparam int F_RD2 = 3;
   localparam int F_EXT = 4;

   // Encoded as {main_v, skid_v}; 2'b01 cannot be reached.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FULL  = 2'b10,
      ST_SKID  = 2'b11
   } stage_state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with enable and synchronous clear.
module pipe_sat_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (en && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a 1-entry skid buffer and synchronous flush.
// Define PIPE_PERF_EN to add the saturating stall_cnt / bubble_cnt outputs.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int NUM_FIELDS = 5,
   parameter int FIELD_W    = FIELD_W_DEF,
   parameter int CNT_W      = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_FIELDS*FIELD_W-1:0] in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_FIELDS*FIELD_W-1:0] out_data
`ifdef PIPE_PERF_EN
   ,
   output logic [CNT_W-1:0]              stall_cnt,
   output logic [CNT_W-1:0]              bubble_cnt
`endif
);

   localparam int DW = NUM_FIELDS * FIELD_W;

   if (NUM_FIELDS < 1 || FIELD_W < 1 || CNT_W < 1) begin : g_param_check
      $error("pipe_stage_reg: NUM_FIELDS, FIELD_W and CNT_W must be positive");
   end

   stage_state_e   state, state_nxt;
   logic [DW-1:0]  main_d, main_nxt;
   logic [DW-1:0]  skid_d, skid_nxt;
   logic           acc, drn;

   // in_ready and out_valid are bits of the state register itself.
   assign out_valid = state[1];
   assign in_ready  = ~state[0];
   assign out_data  = main_d;

   assign acc = in_valid & in_ready;
   assign drn = out_valid & out_ready;

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      main_nxt  = main_d;
      skid_nxt  = skid_d;
      unique case (state)
         ST_EMPTY: begin
            if (acc) begin
               main_nxt  = in_data;
               state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (acc && drn) begin
               main_nxt  = in_data;
            end else if (drn) begin
               main_nxt  = '0;
               state_nxt = ST_EMPTY;
            end else if (acc) begin
               skid_nxt  = in_data;
               state_nxt = ST_SKID;
            end
         end
         ST_SKID: begin
            if (drn) begin
               main_nxt  = skid_d;
               skid_nxt  = '0;
               state_nxt = ST_FULL;
            end
         end
         default: begin
            main_nxt  = '0;
            skid_nxt  = '0;
            state_nxt = ST_EMPTY;
         end
      endcase
   end

   // NOTE: data registers are cleared too, because out_data must read zero
   // (a NOP bubble) whenever the stage is empty; sequential state uses <= only.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state  <= ST_EMPTY;
         main_d <= '0;
         skid_d <= '0;
      end else begin
         state  <= state_nxt;
         main_d <= main_nxt;
         skid_d <= skid_nxt;
      end
   end

`ifdef PIPE_PERF_EN
   // Counters see pre-flush state and are cleared by reset alone.
   pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (reset),
      .en    (out_valid & ~out_ready),
      .count (stall_cnt)
   );

   pipe_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .clear (reset),
      .en    (~out_valid),
      .count (bubble_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed test-plan scenarios then
// random traffic, checked every cycle against a queue-based occupancy model.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int NUM_FIELDS = 5;
   localparam int FIELD_W    = FIELD_W_DEF;
   localparam int CNT_W      = 4;
   localparam int DW         = NUM_FIELDS * FIELD_W;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   typedef logic [DW-1:0] bundle_t;

   logic    clk = 1'b0;
   logic    reset, flush, in_valid, in_ready, out_valid, out_ready;
   bundle_t in_data, out_data;
`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt, bubble_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Scoreboard: bundles accepted but not yet drained, oldest first.
   bundle_t sb_q[$];
   bit      armed = 1'b0;
   int      stall_m, bubble_m;

   pipe_stage_reg #(
      .NUM_FIELDS (NUM_FIELDS),
      .FIELD_W    (FIELD_W),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data)
`ifdef PIPE_PERF_EN
      ,
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input bundle_t act, input bundle_t exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic bundle_t mk(input word_t ir, input word_t pc);
      bundle_t b;
      b = '0;
      b[F_IR*FIELD_W +: FIELD_W] = ir;
      b[F_PC*FIELD_W +: FIELD_W] = pc;
      return b;
   endfunction

   function automatic word_t ir_of(input bundle_t b);
      return b[F_IR*FIELD_W +: FIELD_W];
   endfunction

   // Monitor: compare DUT against the model, then advance the model by the
   // coming clock edge using the inputs currently applied.
   always @(negedge clk) begin
      bit ov_m, rdy_m;
      ov_m  = sb_q.size() > 0;
      rdy_m = sb_q.size() < 2;
      if (armed) begin
         check("out_valid", bundle_t'(out_valid), bundle_t'(ov_m));
         check("in_ready", bundle_t'(in_ready), bundle_t'(rdy_m));
         check("out_data", out_data, ov_m ? sb_q[0] : bundle_t'(0));
`ifdef PIPE_PERF_EN
         check("stall_cnt", bundle_t'(stall_cnt), bundle_t'(stall_m));
         check("bubble_cnt", bundle_t'(bubble_cnt), bundle_t'(bubble_m));
`endif
      end
      if (reset) begin
         stall_m  = 0;
         bubble_m = 0;
      end else begin
         if (ov_m && !out_ready && stall_m < CNT_MAX) stall_m++;
         if (!ov_m && bubble_m < CNT_MAX) bubble_m++;
      end
      if (reset || flush) begin
         sb_q.delete();
      end else begin
         if (ov_m && out_ready) void'(sb_q.pop_front());
         if (in_valid && rdy_m) sb_q.push_back(in_data);
      end
      if (reset) armed = 1'b1;
   end

   task automatic step(input bit iv, input bundle_t d, input bit ordy,
                       input bit fl = 1'b0, input bit rs = 1'b0);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      reset     = rs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bundle_t a, b, c, r;
      a = mk(32'h0000_1111, 32'h0000_0100);
      b = mk(32'h0000_2222, 32'h0000_0104);
      c = mk(32'hDEAD_0000 | 32'h0000_DEAD, 32'h0000_0108);

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      #1;

      // Idle after reset.
      repeat (10) step(1'b0, '0, 1'b1);
      check("idle_out_valid", bundle_t'(out_valid), '0);
      check("idle_in_ready", bundle_t'(in_ready), bundle_t'(1));
      check("idle_ir_nop", bundle_t'(ir_of(out_data)), bundle_t'(NOP_INSTR));
`ifdef PIPE_PERF_EN
      check("idle_bubble_cnt", bundle_t'(bubble_cnt), bundle_t'(CNT_MAX < 10 ? CNT_MAX : 10));
`endif

      // Streaming at full rate.
      step(1'b1, mk(32'h2001_0005, 32'h0000_3000), 1'b1);
      check("stream_ir0", bundle_t'(ir_of(out_data)), bundle_t'(32'h2001_0005));
      check("stream_pc0", bundle_t'(out_data[F_PC*FIELD_W +: FIELD_W]), bundle_t'(32'h0000_3000));
      step(1'b1, mk(32'h2002_0007, 32'h0000_3004), 1'b1);
      check("stream_ir1", bundle_t'(ir_of(out_data)), bundle_t'(32'h2002_0007));
      check("stream_ready", bundle_t'(in_ready), bundle_t'(1));
      step(1'b0, '0, 1'b1);

      // Backpressure fills the skid buffer, then drains in order.
      step(1'b1, a, 1'b0);
      step(1'b1, b, 1'b0);
      check("bp_in_ready", bundle_t'(in_ready), '0);
      check("bp_hold_a", out_data, a);
      step(1'b0, '0, 1'b0);
      check("bp_still_a", out_data, a);
      step(1'b0, '0, 1'b1);
      check("bp_b_next", out_data, b);
      check("bp_ready_back", bundle_t'(in_ready), bundle_t'(1));
      step(1'b0, '0, 1'b1);

      // Flush in SKID drops both bundles.
      step(1'b1, a, 1'b0);
      step(1'b1, b, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      check("flush_skid_valid", bundle_t'(out_valid), '0);
      check("flush_skid_data", out_data, '0);
      check("flush_skid_ready", bundle_t'(in_ready), bundle_t'(1));

      // Flush with a simultaneous accept discards the new bundle.
      step(1'b1, a, 1'b0);
      step(1'b1, c, 1'b0, 1'b1);
      check("flush_acc_valid", bundle_t'(out_valid), '0);
      step(1'b0, '0, 1'b1);

      // Reset and flush together.
      step(1'b1, a, 1'b0);
      step(1'b1, b, 1'b0, 1'b1, 1'b1);
      check("rst_flush_valid", bundle_t'(out_valid), '0);
      check("rst_flush_ready", bundle_t'(in_ready), bundle_t'(1));

`ifdef PIPE_PERF_EN
      // Stall counter saturation survives a flush.
      step(1'b1, a, 1'b0);
      repeat (20) step(1'b0, '0, 1'b0);
      check("stall_sat", bundle_t'(stall_cnt), bundle_t'(CNT_MAX));
      step(1'b0, '0, 1'b0, 1'b1);
      check("stall_after_flush", bundle_t'(stall_cnt), bundle_t'(CNT_MAX));
`endif

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < NUM_FIELDS; k++) r[k*FIELD_W +: FIELD_W] = FIELD_W'($urandom);
         step(($urandom_range(0, 3) != 0), r, ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 40) == 0), ($urandom_range(0, 400) == 0));
      end
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
